// File: rtl/pwm_deadtime_pkg.sv
// Shared types for the complementary gate-drive stage with dead band.
package pwm_deadtime_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    HI_ON    = 3'd1,
    DT_TO_LO = 3'd2,
    LO_ON    = 3'd3,
    DT_TO_HI = 3'd4
  } pwm_dt_state_t;

  function automatic logic is_dt(input pwm_dt_state_t s);
    return (s == DT_TO_LO) || (s == DT_TO_HI);
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/gate bundle between the PWM source side and the dead-time stage.
interface pwm_deadtime_if #(parameter int DT_SIZE = 8);
  logic               pwm_in;
  logic [DT_SIZE-1:0] dead_time;
  logic               enable;
  logic               fault;
  logic               fault_clr;
  logic               pwm_hi;
  logic               pwm_lo;
  logic               fault_lat;

  modport master (output pwm_in, dead_time, enable, fault, fault_clr,
                  input  pwm_hi, pwm_lo, fault_lat);
  modport slave  (input  pwm_in, dead_time, enable, fault, fault_clr,
                  output pwm_hi, pwm_lo, fault_lat);
endinterface

// File: rtl/pwm_deadtime.sv
// Single-ended PWM to complementary high/low gate pair with dead band,
// enable gating and sticky fault shutdown. Outputs never both high.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  pwm_deadtime_if.slave   bus
);

  pwm_dt_state_t      state_q, state_d;
  logic [DT_SIZE-1:0] dt_cnt, dt_d;
  logic               hi_d, lo_d, fault_lat_d;
  logic               dt_zero;

  assign dt_zero = (bus.dead_time == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OFF;
      dt_cnt        <= '0;
      bus.pwm_hi    <= 1'b0;
      bus.pwm_lo    <= 1'b0;
      bus.fault_lat <= 1'b0;
    end else begin
      state_q       <= state_d;
      dt_cnt        <= dt_d;
      bus.pwm_hi    <= hi_d;
      bus.pwm_lo    <= lo_d;
      bus.fault_lat <= fault_lat_d;
    end
  end

  // Shutdown conditions dominate; fault_lat uses the registered value so a
  // restart happens one cycle after the clear.
  always_comb begin
    state_d = state_q;
    if (bus.fault || !bus.enable || bus.fault_lat) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:      state_d = bus.pwm_in ? (dt_zero ? HI_ON : DT_TO_HI)
                                       : (dt_zero ? LO_ON : DT_TO_LO);
        HI_ON:    if (!bus.pwm_in) state_d = dt_zero ? LO_ON : DT_TO_LO;
        LO_ON:    if (bus.pwm_in)  state_d = dt_zero ? HI_ON : DT_TO_HI;
        DT_TO_LO: if (bus.pwm_in)  state_d = HI_ON;
                  else if (dt_cnt == '0) state_d = LO_ON;
        DT_TO_HI: if (!bus.pwm_in) state_d = LO_ON;
                  else if (dt_cnt == '0) state_d = HI_ON;
        default:  state_d = OFF;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    hi_d = (state_d == HI_ON);
    lo_d = (state_d == LO_ON);
    dt_d = '0;
    if (is_dt(state_d) && (state_d != state_q))
      dt_d = bus.dead_time - DT_SIZE'(1);
    else if (is_dt(state_d) && (dt_cnt != '0))
      dt_d = dt_cnt - DT_SIZE'(1);
    fault_lat_d = bus.fault_lat;
    if (bus.fault)          fault_lat_d = 1'b1;
    else if (bus.fault_clr) fault_lat_d = 1'b0;
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed scoreboard bench for pwm_deadtime: expected gate/fault values are
// queued with each stimulus step and checked one edge later.
module tb_pwm_deadtime;

  localparam int DT_SIZE = 8;

  typedef struct {
    logic  hi;
    logic  lo;
    logic  fl;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  pwm_deadtime_if #(.DT_SIZE(DT_SIZE)) ifc ();

  pwm_deadtime #(.DT_SIZE(DT_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Gates must never overlap, including reset and mid-band.
  always @(negedge clk) begin
    n_cmp++;
    assert (!(ifc.pwm_hi === 1'b1 && ifc.pwm_lo === 1'b1)) else begin
      n_err++;
      $error("FAIL overlap: hi=%b lo=%b required not both 1", ifc.pwm_hi, ifc.pwm_lo);
    end
  end

  task automatic step(input logic p, input logic [DT_SIZE-1:0] dt, input logic en,
                      input logic f, input logic fc,
                      input logic eh, input logic el, input logic efl, input string tag);
    exp_t e;
    ifc.pwm_in    = p;
    ifc.dead_time = dt;
    ifc.enable    = en;
    ifc.fault     = f;
    ifc.fault_clr = fc;
    sb.push_back('{eh, el, efl, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    assert ({ifc.pwm_hi, ifc.pwm_lo, ifc.fault_lat} === {e.hi, e.lo, e.fl}) else begin
      n_err++;
      $error("FAIL %s: hi/lo/fl=%b%b%b required %b%b%b", e.tag,
             ifc.pwm_hi, ifc.pwm_lo, ifc.fault_lat, e.hi, e.lo, e.fl);
    end
  endtask

  initial begin
    ifc.pwm_in = 0; ifc.dead_time = '0; ifc.enable = 0; ifc.fault = 0; ifc.fault_clr = 0;
    @(posedge clk); #1;
    // reset state
    step(0, 8'd3, 0, 0, 0, 0, 0, 0, "reset");
    rst = 0;
    // start with dead_time=3 into LO_ON
    step(0, 8'd3, 1, 0, 0, 0, 0, 0, "start_band1");
    step(0, 8'd3, 1, 0, 0, 0, 0, 0, "start_band2");
    step(0, 8'd3, 1, 0, 0, 0, 0, 0, "start_band3");
    step(0, 8'd3, 1, 0, 0, 0, 1, 0, "lo_on");
    step(0, 8'd3, 1, 0, 0, 0, 1, 0, "lo_hold");
    step(1, 8'd3, 1, 0, 0, 0, 0, 0, "lo_fall");
    step(1, 8'd3, 1, 0, 0, 0, 0, 0, "band_hi2");
    step(1, 8'd3, 1, 0, 0, 0, 0, 0, "band_hi3");
    step(1, 8'd3, 1, 0, 0, 1, 0, 0, "hi_rise");
    // dead_time=0 toggling: one-edge switch
    step(0, 8'd0, 1, 0, 0, 0, 1, 0, "dt0_lo");
    step(1, 8'd0, 1, 0, 0, 1, 0, 0, "dt0_hi");
    step(0, 8'd0, 1, 0, 0, 0, 1, 0, "dt0_lo2");
    step(1, 8'd0, 1, 0, 0, 1, 0, 0, "dt0_hi2");
    // dead_time=5 into LO_ON, then short high pulse aborts
    step(0, 8'd5, 1, 0, 0, 0, 0, 0, "dt5_fall");
    for (int i = 0; i < 4; i++) step(0, 8'd5, 1, 0, 0, 0, 0, 0, "dt5_band");
    step(0, 8'd5, 1, 0, 0, 0, 1, 0, "dt5_lo_on");
    step(1, 8'd5, 1, 0, 0, 0, 0, 0, "pulse_1");
    step(1, 8'd5, 1, 0, 0, 0, 0, 0, "pulse_2");
    step(0, 8'd5, 1, 0, 0, 0, 1, 0, "abort_lo");
    step(0, 8'd5, 1, 0, 0, 0, 1, 0, "abort_hold");
    // fault during HI_ON, ignored clear, then real clear and resume through band
    step(1, 8'd0, 1, 0, 0, 1, 0, 0, "pre_fault_hi");
    step(1, 8'd0, 1, 1, 0, 0, 0, 1, "fault_trip");
    step(1, 8'd0, 1, 1, 1, 0, 0, 1, "clr_ignored");
    step(1, 8'd0, 1, 0, 0, 0, 0, 1, "fault_hold");
    step(1, 8'd2, 1, 0, 1, 0, 0, 0, "fault_clear");
    step(1, 8'd2, 1, 0, 0, 0, 0, 0, "resume_band1");
    step(1, 8'd2, 1, 0, 0, 0, 0, 0, "resume_band2");
    step(1, 8'd2, 1, 0, 0, 1, 0, 0, "resume_hi");
    // enable drop mid DT_TO_HI; dead_time change applies only at reload
    step(0, 8'd0, 1, 0, 0, 0, 1, 0, "pre_en_lo");
    step(1, 8'd4, 1, 0, 0, 0, 0, 0, "band4_start");
    step(1, 8'd7, 1, 0, 0, 0, 0, 0, "band4_dtchg");
    step(1, 8'd7, 0, 0, 0, 0, 0, 0, "en_drop");
    step(1, 8'd7, 1, 0, 0, 0, 0, 0, "band7_start");
    for (int i = 0; i < 6; i++) step(1, 8'd7, 1, 0, 0, 0, 0, 0, "band7");
    step(1, 8'd7, 1, 0, 0, 1, 0, 0, "band7_hi");
    // reset mid-band, then start with dead_time=0
    step(0, 8'd3, 1, 0, 0, 0, 0, 0, "rst_pre_band");
    rst = 1;
    step(0, 8'd3, 1, 0, 0, 0, 0, 0, "rst_mid_band");
    rst = 0;
    step(0, 8'd0, 1, 0, 0, 0, 1, 0, "dt0_start_lo");
    step(0, 8'd0, 1, 1, 0, 0, 0, 1, "fault_again");
    rst = 1;
    step(0, 8'd0, 1, 0, 0, 0, 0, 0, "rst_clr_fault");
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
